gray_fifo_ctrl: RTL and testbench

GRAY_FIFO_CTRL -- requirements
Module: gray_fifo_ctrl

---
 rtl/gray_fifo_ctrl_pkg.sv | 29 ++
 rtl/gray_ptr.sv | 34 +++
 rtl/gray_fifo_ctrl.sv | 92 +++++++++
 tb/tb_gray_fifo_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gray_fifo_ctrl_pkg.sv
// Shared pointer helpers for the Gray-coded FIFO controllers (single- and
// dual-clock). Functions work on a fixed maximum width; callers zero-extend
// their pointers in and truncate results back to their own width.
package gray_fifo_ctrl_pkg;

  // Widest pointer supported: awidth up to 16, plus the wrap bit.
  localparam int PTR_MAX_W = 17;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  // Binary to reflected Gray code.
  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Empty: both pointers identical, including the wrap bit.
  function automatic logic ptr_empty(input ptr_t a, input ptr_t b);
    return a == b;
  endfunction

  // Full: wrap bits differ, address bits equal. Width w is the pointer width
  // (awidth+1), so the wrap bit sits at position w-1.
  function automatic logic ptr_full(input ptr_t a, input ptr_t b, input int w);
    ptr_t msb;
    msb = ptr_t'(1) << (w - 1);
    return (a ^ b) == msb;
  endfunction

endpackage

// File: rtl/gray_ptr.sv
// One FIFO pointer held as a binary/Gray register pair. Both registers load
// from the same next-binary value, so GRAY always equals bin2gray(BIN).
module gray_ptr
  import gray_fifo_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         INC,
  input  logic         CLR,
  output logic [W-1:0] BIN,
  output logic [W-1:0] GRAY
);

  logic [W-1:0] bin_nxt;

  // Next pointer: flush to zero, else advance by one with natural wrap.
  always_comb begin
    bin_nxt = CLR ? '0 : BIN + W'(INC);
  end

  // Binary and Gray registers updated together on every edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BIN  <= '0;
      GRAY <= '0;
    end else begin
      BIN  <= bin_nxt;
      GRAY <= W'(bin2gray(ptr_t'(bin_nxt)));
    end
  end

endmodule

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO controller with Gray-coded pointers. Produces RAM write
// strobe and addresses plus registered occupancy and status flags. Flags are
// derived from the next pointer values so they change on the same edge as
// the pointers.
module gray_fifo_ctrl
  import gray_fifo_ctrl_pkg::*;
#(
  parameter int awidth    = 3,
  parameter int afull_lvl = 2**awidth - 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENQ,
  input  logic              DEQ,
  input  logic              CLR,
  output logic              WE,
  output logic [awidth-1:0] WADDR,
  output logic [awidth-1:0] RADDR,
  output logic [awidth:0]   WPTR_G,
  output logic [awidth:0]   RPTR_G,
  output logic [awidth:0]   COUNT,
  output logic              FULL_N,
  output logic              EMPTY_N,
  output logic              AFULL
);

  localparam int PW = awidth + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(afull_lvl);

  logic          enq_acc;
  logic          deq_acc;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin;
  logic [PW-1:0] wbin_nxt;
  logic [PW-1:0] rbin_nxt;
  logic [PW-1:0] count_nxt;
  logic          full_nxt;
  logic          empty_nxt;

  // Acceptance: blocked requests are dropped, CLR and RST suppress both.
  always_comb begin
    enq_acc = ENQ & FULL_N  & ~CLR & ~RST;
    deq_acc = DEQ & EMPTY_N & ~CLR & ~RST;
  end

  assign WE    = enq_acc;
  assign WADDR = wbin[awidth-1:0];
  assign RADDR = rbin[awidth-1:0];

  gray_ptr #(.W(PW)) u_wptr (
    .CLK  (CLK),
    .RST  (RST),
    .INC  (enq_acc),
    .CLR  (CLR),
    .BIN  (wbin),
    .GRAY (WPTR_G)
  );

  gray_ptr #(.W(PW)) u_rptr (
    .CLK  (CLK),
    .RST  (RST),
    .INC  (deq_acc),
    .CLR  (CLR),
    .BIN  (rbin),
    .GRAY (RPTR_G)
  );

  // Next pointers mirror the gray_ptr update; flags and count follow from them.
  always_comb begin
    wbin_nxt  = CLR ? '0 : wbin + PW'(enq_acc);
    rbin_nxt  = CLR ? '0 : rbin + PW'(deq_acc);
    count_nxt = wbin_nxt - rbin_nxt;
    empty_nxt = ptr_empty(ptr_t'(wbin_nxt), ptr_t'(rbin_nxt));
    full_nxt  = ptr_full(ptr_t'(wbin_nxt), ptr_t'(rbin_nxt), PW);
  end

  // Registered occupancy and status flags, same edge as the pointers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      COUNT   <= '0;
      FULL_N  <= 1'b1;
      EMPTY_N <= 1'b0;
      AFULL   <= 1'b0;
    end else begin
      COUNT   <= count_nxt;
      FULL_N  <= ~full_nxt;
      EMPTY_N <= ~empty_nxt;
      AFULL   <= (count_nxt >= AFULL_LVL);
    end
  end

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Directed bench for gray_fifo_ctrl with awidth=3, afull_lvl=6.
module tb_gray_fifo_ctrl;

  logic       CLK;
  logic       RST;
  logic       ENQ;
  logic       DEQ;
  logic       CLR;
  logic       WE;
  logic [2:0] WADDR;
  logic [2:0] RADDR;
  logic [3:0] WPTR_G;
  logic [3:0] RPTR_G;
  logic [3:0] COUNT;
  logic       FULL_N;
  logic       EMPTY_N;
  logic       AFULL;

  int n_chk  = 0;
  int n_pass = 0;

  gray_fifo_ctrl #(.awidth(3), .afull_lvl(6)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .ENQ     (ENQ),
    .DEQ     (DEQ),
    .CLR     (CLR),
    .WE      (WE),
    .WADDR   (WADDR),
    .RADDR   (RADDR),
    .WPTR_G  (WPTR_G),
    .RPTR_G  (RPTR_G),
    .COUNT   (COUNT),
    .FULL_N  (FULL_N),
    .EMPTY_N (EMPTY_N),
    .AFULL   (AFULL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"},   COUNT,   0);
    chk({tag, "_full_n"},  FULL_N,  1);
    chk({tag, "_empty_n"}, EMPTY_N, 0);
    chk({tag, "_afull"},   AFULL,   0);
    chk({tag, "_wptr_g"},  WPTR_G,  0);
    chk({tag, "_rptr_g"},  RPTR_G,  0);
    chk({tag, "_we"},      WE,      0);
  endtask

  logic [3:0] wexp, rexp, wg_prev, rg_prev;

  initial begin
    RST = 1'b1; ENQ = 1'b1; DEQ = 1'b0; CLR = 1'b0;
    step(); step();
    chk_reset_state("rst");
    RST = 1'b0; ENQ = 1'b0;
    #1;

    // Fill: 8 enqueues, AFULL rises on the edge taking occupancy to 6.
    for (int i = 0; i < 8; i++) begin
      ENQ = 1'b1;
      #1;
      chk("fill_we", WE, 1);
      chk("fill_waddr", WADDR, i);
      step();
      chk("fill_count", COUNT, i + 1);
      chk("fill_afull", AFULL, (i + 1) >= 6);
    end
    chk("full_full_n", FULL_N, 0);
    chk("full_empty_n", EMPTY_N, 1);
    chk("full_wptr_g", WPTR_G, 4'b1100);

    // 9th enqueue is dropped.
    #1;
    chk("ovf_we", WE, 0);
    step();
    chk("ovf_count", COUNT, 8);
    chk("ovf_wptr_g", WPTR_G, 4'b1100);
    chk("ovf_rptr_g", RPTR_G, 4'b0000);

    // ENQ+DEQ at full: only the dequeue is accepted.
    DEQ = 1'b1;
    #1;
    chk("fulld_we", WE, 0);
    step();
    chk("fulld_rptr_g", RPTR_G, 4'b0001);
    chk("fulld_wptr_g", WPTR_G, 4'b1100);
    chk("fulld_count", COUNT, 7);
    chk("fulld_full_n", FULL_N, 1);

    // Drain the remaining 7 entries.
    ENQ = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("drain_count", COUNT, 0);
    chk("drain_empty_n", EMPTY_N, 0);
    chk("drain_rptr_g", RPTR_G, 4'b1100);
    chk("drain_raddr", RADDR, 0);

    // DEQ alone at empty: no change.
    step();
    chk("udf_count", COUNT, 0);
    chk("udf_rptr_g", RPTR_G, 4'b1100);

    // ENQ+DEQ at empty: only the enqueue (wbin 8->9).
    ENQ = 1'b1;
    #1;
    chk("emptyd_we", WE, 1);
    step();
    chk("emptyd_count", COUNT, 1);
    chk("emptyd_empty_n", EMPTY_N, 1);
    chk("emptyd_rptr_g", RPTR_G, 4'b1100);
    chk("emptyd_wptr_g", WPTR_G, 4'b1101);

    // Three more enqueues -> occupancy 4 (wbin=12, rbin=8).
    DEQ = 1'b0;
    step(); step(); step();
    chk("c4_count", COUNT, 4);

    // 20 cycles of ENQ+DEQ at occupancy 4.
    wexp = 4'd12; rexp = 4'd8;
    DEQ = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wg_prev = WPTR_G; rg_prev = RPTR_G;
      step();
      wexp = wexp + 4'd1; rexp = rexp + 4'd1;
      chk("ss_count", COUNT, 4);
      chk("ss_wptr_g", WPTR_G, g(wexp));
      chk("ss_rptr_g", RPTR_G, g(rexp));
      chk("ss_wg_1bit", $countones(wg_prev ^ WPTR_G), 1);
      chk("ss_rg_1bit", $countones(rg_prev ^ RPTR_G), 1);
    end
    chk("ss_wrap_wptr", WPTR_G, 4'b0000);
    chk("ss_afull", AFULL, 0);

    // Up to 6, then CLR with ENQ held.
    DEQ = 1'b0;
    step(); step();
    chk("c6_count", COUNT, 6);
    chk("c6_afull", AFULL, 1);
    CLR = 1'b1;
    #1;
    chk("clr_we", WE, 0);
    step();
    CLR = 1'b0; ENQ = 1'b0;
    #1;
    chk_reset_state("clr");

    // Occupancy 3, then asynchronous reset mid-cycle.
    ENQ = 1'b1;
    step(); step(); step();
    chk("c3_count", COUNT, 3);
    #2;
    RST = 1'b1;
    #1;
    chk_reset_state("arst");
    step();
    RST = 1'b0;
    #1;
    chk("post_rst_waddr", WADDR, 0);
    step();
    chk("post_rst_count", COUNT, 1);
    chk("post_rst_wptr_g", WPTR_G, 4'b0001);
    chk("post_rst_empty_n", EMPTY_N, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
